// File: rtl/h80_uart_rx_if.sv
// CPU-side read/status bundle for the h80 UART receiver.
// The receiver is the slave; the polling CPU I/O block is the master.
interface h80_uart_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rx_avail;
    logic [CW-1:0] rx_count;
    logic          overrun;
    logic          frame_err;
    logic          clr_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rx_avail, rx_count, overrun, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rx_avail, rx_count, overrun, frame_err
    );
endinterface

// File: rtl/h80_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// show-ahead receive FIFO with sticky overrun / framing-error flags.
//
//   state    | meaning
//   ST_IDLE  | line idle, waiting for rx_s low
//   ST_START | counting to middle of start bit, then confirm it is still low
//   ST_DATA  | sampling 8 data bits LSB first, one per bit period
//   ST_STOP  | sampling stop bit; high pushes the byte, low flags framing error
//   ST_BRK   | after a framing error, wait for the line to return high
module h80_uart_rx #(
    parameter int SYSCLK_FREQ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic            sysclk,
    input  logic            reset_n,
    input  logic            uart_rxp,
    h80_uart_rx_if.slave    bus
);
    localparam int DIV = SYSCLK_FREQ / BAUD;
    localparam int BCW = $clog2(DIV + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    // Reloading DIV-1 gives exactly DIV cycles between samples, since the
    // expiry cycle itself counts as one of them.
    localparam logic [BCW-1:0] HALF   = BCW'(DIV / 2);
    localparam logic [BCW-1:0] PERIOD = BCW'(DIV - 1);
    localparam logic [CW-1:0]  FULL   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    logic [1:0]     sync;
    logic           rx_s;
    state_t         state;
    logic [BCW-1:0] baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  rptr;
    logic [PW-1:0]  wptr;
    logic [CW-1:0]  count;
    logic           overrun_q;
    logic           frame_err_q;

    logic           stop_hit;
    logic           push;
    logic           push_ok;
    logic           pop;
    logic           drop;
    logic           ferr_set;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], uart_rxp};
        end
    end

    assign rx_s = sync[1];

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        if (!rx_s) begin
                            baud_cnt <= PERIOD;
                            bit_idx  <= '0;
                            state    <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        shreg[bit_idx] <= rx_s;
                        baud_cnt       <= PERIOD;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= rx_s ? ST_IDLE : ST_BRK;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_BRK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Push and error act on the stop-sample edge itself so the byte is
    // visible one cycle after the stop sample.
    assign stop_hit = (state == ST_STOP) && (baud_cnt == '0);
    assign push     = stop_hit && rx_s;
    assign ferr_set = stop_hit && !rx_s;
    assign pop      = bus.rd_en && (count != '0);
    assign push_ok  = push && ((count != FULL) || pop);
    assign drop     = push && !push_ok;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_err) begin
                overrun_q <= 1'b0;
            end
            if (ferr_set) begin
                frame_err_q <= 1'b1;
            end else if (bus.clr_err) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge sysclk) begin
        if (push_ok) begin
            mem[wptr] <= shreg;
        end
    end

    assign bus.rd_data   = (count == '0) ? 8'h00 : mem[rptr];
    assign bus.rx_avail  = (count != '0);
    assign bus.rx_count  = count;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: doc/h80_uart_rx.md
# h80_uart_rx

Serial receiver for the h80 UART path: oversamples the asynchronous `uart_rxp` pin in the `sysclk` domain, deframes 8N1 characters, and queues received bytes in a small show-ahead FIFO. It sits directly upstream of the CPU I/O block, which polls `rx_avail`, reads `rd_data` and pops with `rd_en`, completing the serial-echo loop alongside the existing `uart_txp` transmitter.

## Interface

- `SYSCLK_FREQ`, 27000000, sysclk frequency in Hz
- `BAUD`, 115200, line rate; `DIV = SYSCLK_FREQ/BAUD` (integer truncation, 234 at defaults, must be ≥ 4)
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, ≥ 2
- `sysclk  in  1  single clock; all state on rising edge`
- `reset_n  in  1  asynchronous, active-low reset`
- `uart_rxp  in  1  asynchronous serial input, idle high`
- `rd_en  in  1  pop oldest byte; ignored when FIFO empty`
- `rd_data  out  8  oldest byte (show-ahead); 8'h00 when empty`
- `rx_avail  out  1  FIFO non-empty`
- `rx_count  out  $clog2(FIFO_DEPTH+1)  bytes held`
- `overrun  out  1  sticky: byte dropped because FIFO full`
- `frame_err  out  1  sticky: stop bit sampled low`
- `clr_err  in  1  clears both sticky flags`

Clock and reset are fixed: one clock, `sysclk`; reset is asynchronous and active-low, `reset_n`.

## Operation

- Input synchroniser: two flops, reset to 1; output `rx_s`.
- Receiver FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s`=0, load baud counter with `DIV/2`, go START.
  - START: at counter expiry sample `rx_s`; 0 → reload `DIV`, bit index 0, go DATA; 1 → false start, go IDLE.
  - DATA: at each expiry shift `rx_s` into bit `index` (LSB first), reload `DIV`; after bit 7 go STOP.
  - STOP: at expiry, 1 → push byte, go IDLE; 0 → discard byte, set `frame_err`, go BREAK.
  - BREAK: wait until `rx_s`=1, then IDLE (no new start detected while line held low).
- Baud counter: down-counter, expiry = value 0 at reload point; width `$clog2(DIV+1)`.
- FIFO: circular buffer, read/write pointers `$clog2(FIFO_DEPTH)` bits wrapping naturally; `rx_count` tracked separately.
  - Push accepted if `rx_count < FIFO_DEPTH`, or if full and `rd_en` asserted the same cycle (pop and push both occur, count unchanged).
  - Push while full without pop: byte dropped, `overrun` set, FIFO contents unchanged.
  - `rd_en` with empty FIFO: no effect; count never underflows.
  - Simultaneous push and pop when count=1: pop old byte, new byte becomes head, count stays 1.
- Sticky flags: set has priority over `clr_err` in the same cycle.
- Reset mid-character: FSM to IDLE, partial byte discarded, FIFO emptied.

## Timing

- Reset values: `rd_data`=8'h00, `rx_avail`=0, `rx_count`=0, `overrun`=0, `frame_err`=0, FSM IDLE, synchroniser 1.
- Synchroniser latency: 2 cycles from pin to `rx_s`.
- Let t0 = first cycle `rx_s`=0 in IDLE. Sample k (0=start, 1..8=data, 9=stop) occurs at t0 + `DIV/2` + k·`DIV` + 1.
- Push registered at the stop-sample edge; `rx_avail`, `rx_count`, `rd_data` update on the following cycle (1-cycle latency from stop sample).
- Pop: `rd_data` shows next byte and `rx_count` decrements the cycle after `rd_en`.
- Back-to-back characters: a start edge one cycle after STOP→IDLE is detected; no dead time required beyond the stop bit.

## Test plan

Bench parameters: `SYSCLK_FREQ`=1600, `BAUD`=100 (`DIV`=16), `FIFO_DEPTH`=4.

- Send 8'hA5 as 8N1 at 16 cycles/bit → `rx_avail` rises 1 cycle after stop sample, `rd_data`=8'hA5, `rx_count`=1; `rd_en` one cycle → `rx_avail`=0, `rx_count`=0.
- Send 8'h01, 8'h80, 8'hFF, 8'h00 back-to-back → pop order 01, 80, FF, 00; `rx_count` peaks at 4, no `overrun`.
- Send 5 bytes 8'h10..8'h14 without reading → `overrun`=1, FIFO holds 10..13; `clr_err` → `overrun`=0; repeat with `rd_en` coincident with 5th push → 14 stored, no overrun.
- Send 8'h3C with stop bit low, hold line low 40 cycles, then send 8'h55 → `frame_err`=1, 3C not stored, 55 received correctly.
- 4-cycle low glitch on idle line → false start, nothing pushed, no flags; then 8'h69 received.
- Assert `reset_n`=0 during data bit 4 of 8'h77 with 2 bytes queued → all outputs at reset values; after release a fresh 8'h42 is received as the only entry.
